bfly_pair_commutator: RTL and testbench

BFLY_PAIR_COMMUTATOR -- requirements
Module: bfly_pair_commutator

---
 rtl/bfly_pair_commutator_pkg.sv | 13 +
 rtl/bfly_pair_commutator.sv | 105 ++++++++++
 tb/tb_bfly_pair_commutator.sv | 129 ++++++++++++
 3 files changed

// File: rtl/bfly_pair_commutator_pkg.sv
// bfly_pair_commutator_pkg: shared sample type and default pair distance for the radix-2 DIF datapath
// Contents: complex_product_t (signed real/imag pair), BFLY_DEPTH default, SAMPLE_W sample width.
package bfly_pair_commutator_pkg;

    localparam int SAMPLE_W   = 16;
    localparam int BFLY_DEPTH = 4;

    typedef struct packed {
        logic signed [SAMPLE_W-1:0] r;
        logic signed [SAMPLE_W-1:0] i;
    } complex_product_t;

endpackage

// File: rtl/bfly_pair_commutator.sv
// bfly_pair_commutator: buffers the first DEPTH samples of a frame and pairs them with the next DEPTH samples
// Ports:
//   clk        - rising-edge clock
//   reset      - asynchronous active-low reset
//   in_valid   - in_data carries a sample this cycle
//   in_data    - serial complex input sample
//   sync       - restarts the frame; a valid sample this cycle becomes x[0]
//   A, B       - registered pair x[k], x[k+DEPTH]
//   out_valid  - A/B/tw_idx valid this cycle (butterfly enable)
//   tw_idx     - pair index k
//   frame_last - high with the pair k = DEPTH-1
module bfly_pair_commutator
    import bfly_pair_commutator_pkg::*;
#(
    parameter int DEPTH = BFLY_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  complex_product_t         in_data,
    input  logic                     sync,
    output complex_product_t         A,
    output complex_product_t         B,
    output logic                     out_valid,
    output logic [$clog2(DEPTH)-1:0] tw_idx,
    output logic                     frame_last
);

    localparam int CW = $clog2(DEPTH);

    typedef enum logic {FILL, PAIR} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    complex_product_t store_q [DEPTH];
    complex_product_t a_q, a_d, b_q, b_d;
    logic [CW-1:0]    tw_q, tw_d;
    logic             ov_q, ov_d, fl_q, fl_d;
    logic             cnt_last, fire, st_we;
    logic [CW-1:0]    wr_idx;

    assign cnt_last = cnt_q == CW'(DEPTH - 1);
    assign fire     = in_valid && state_q == PAIR;
    // sync restarts the frame, so a sync sample is stored even while pairing
    assign st_we    = in_valid && (sync || state_q == FILL);
    assign wr_idx   = sync ? '0 : cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= FILL;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (sync) begin
            state_d = FILL;
            cnt_d   = in_valid ? CW'(1) : '0;
        end else if (in_valid) begin
            state_d = cnt_last ? (state_q == FILL ? PAIR : FILL) : state_q;
            cnt_d   = cnt_last ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (st_we) store_q[wr_idx] <= in_data;
    end

    // A sync during PAIR still loads the pair data, but the pair is not flagged valid
    always_comb begin
        a_d  = fire ? store_q[cnt_q] : a_q;
        b_d  = fire ? in_data : b_q;
        tw_d = fire ? cnt_q : tw_q;
        ov_d = fire && !sync;
        fl_d = fire && !sync && cnt_last;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_q  <= '0;
            b_q  <= '0;
            tw_q <= '0;
            ov_q <= 1'b0;
            fl_q <= 1'b0;
        end else begin
            a_q  <= a_d;
            b_q  <= b_d;
            tw_q <= tw_d;
            ov_q <= ov_d;
            fl_q <= fl_d;
        end
    end

    assign A          = a_q;
    assign B          = b_q;
    assign tw_idx     = tw_q;
    assign out_valid  = ov_q;
    assign frame_last = fl_q;

endmodule

// File: tb/tb_bfly_pair_commutator.sv
// tb_bfly_pair_commutator: directed self-checking bench for bfly_pair_commutator with DEPTH = 4
module tb_bfly_pair_commutator;
    import bfly_pair_commutator_pkg::*;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             in_valid = 1'b0;
    complex_product_t in_data = '0;
    logic             sync = 1'b0;
    complex_product_t A, B;
    logic             out_valid;
    logic [1:0]       tw_idx;
    logic             frame_last;
    int               checks = 0;
    int               errors = 0;

    bfly_pair_commutator #(.DEPTH(4)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .sync(sync),
        .A(A), .B(B), .out_valid(out_valid), .tw_idx(tw_idx), .frame_last(frame_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input int r, input int i, input logic s);
        in_valid  = v;
        in_data.r = 16'(r);
        in_data.i = 16'(i);
        sync      = s;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        sync     = 1'b0;
    endtask

    task automatic pair(input string tag, input int ar, input int br, input int tw, input logic fl);
        chk({tag, "_ov"}, 32'(out_valid), 32'd1);
        chk({tag, "_a"}, A, {16'(ar), 16'd0});
        chk({tag, "_b"}, B, {16'(br), 16'd0});
        chk({tag, "_tw"}, 32'(tw_idx), 32'(tw));
        chk({tag, "_fl"}, 32'(frame_last), 32'(fl));
    endtask

    task automatic idle_out(input string tag);
        chk({tag, "_ov"}, 32'(out_valid), 32'd0);
        chk({tag, "_fl"}, 32'(frame_last), 32'd0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_a", A, 32'd0);
        chk("rst_b", B, 32'd0);
        chk("rst_tw", 32'(tw_idx), 32'd0);
        idle_out("rst");
        @(negedge clk);
        reset = 1'b1;

        for (int k = 1; k <= 8; k++) begin
            drive(1'b1, k, 0, 1'b0);
            if (k <= 4) idle_out("fill1");
            else pair("frame1", k - 4, k, k - 5, k == 8);
        end
        for (int k = 9; k <= 16; k++) begin
            drive(1'b1, k, 0, 1'b0);
            if (k <= 12) idle_out("fill2");
            else pair("frame2", k - 4, k, k - 13, k == 16);
        end

        for (int k = 1; k <= 8; k++) begin
            drive(1'b1, k, 0, 1'b0);
            if (k <= 4) idle_out("gfill");
            else pair("gpair", k - 4, k, k - 5, k == 8);
            drive(1'b0, 0, 0, 1'b0);
            idle_out("gidle");
            if (k > 4) begin
                chk("gidle_a", A, {16'(k - 4), 16'd0});
                chk("gidle_b", B, {16'(k), 16'd0});
                chk("gidle_tw", 32'(tw_idx), 32'(k - 5));
            end
        end

        for (int k = 1; k <= 6; k++) begin
            drive(1'b1, k, 0, 1'b0);
            if (k > 4) pair("spre", k - 4, k, k - 5, 1'b0);
        end
        drive(1'b1, 20, 0, 1'b1);
        idle_out("ssync");
        for (int k = 21; k <= 27; k++) begin
            drive(1'b1, k, 0, 1'b0);
            if (k <= 23) idle_out("sfill");
            else pair("spair", k - 4, k, k - 24, k == 27);
        end

        for (int k = 1; k <= 6; k++) drive(1'b1, k, 0, 1'b0);
        pair("rpre", 2, 6, 1, 1'b0);
        #2 reset = 1'b0;
        #1;
        chk("arst_a", A, 32'd0);
        chk("arst_b", B, 32'd0);
        chk("arst_tw", 32'(tw_idx), 32'd0);
        idle_out("arst");
        @(negedge clk);
        reset = 1'b1;
        for (int k = 30; k <= 37; k++) begin
            drive(1'b1, k, 0, 1'b0);
            if (k <= 33) idle_out("rfill");
            else pair("rpair", k - 4, k, k - 34, k == 37);
        end

        drive(1'b1, -3, 7, 1'b0);
        for (int k = 1; k <= 3; k++) drive(1'b1, k, 0, 1'b0);
        drive(1'b1, 5, -2, 1'b0);
        chk("neg_ov", 32'(out_valid), 32'd1);
        chk("neg_a", A, {16'hFFFD, 16'h0007});
        chk("neg_b", B, {16'h0005, 16'hFFFE});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
